// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the inter-stage pipeline registers.
//  - Per-stage bundle structs and their widths, so every pipe_stage_buf
//    instance takes its DATA_W from one place.
//  - FSM state encoding used by the skid-buffer variant.
//  - occ_count: occupancy value derived from the two entry valid bits.
// ----------------------------------------------------------------------------
package pipe_pkg;

    // Bundle carried from IF to ID.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  excp;
    } if2id_t;

    // Bundle carried from EX to MEM.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  dest;
        logic        gr_we;
        logic        mem_we;
        logic        mem_re;
        logic [5:0]  excp;
    } ex2mem_t;

    // Bundle carried from MEM to WB.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        gr_we;
        logic [5:0]  excp;
        logic        ertn;
    } mem2wb_t;

    localparam int IF2ID_W  = $bits(if2id_t);
    localparam int EX2MEM_W = $bits(ex2mem_t);
    localparam int MEM2WB_W = $bits(mem2wb_t);

    // States of the 2-entry skid buffer; the encoding equals the occupancy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    // The skid entry is only ever valid while the main entry is valid too,
    // so the two valid bits map directly onto a 0/1/2 count.
    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        return {skid_v, main_v & ~skid_v};
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// ----------------------------------------------------------------------------
// pipe_entry
// One storage slot of a pipeline register: a valid bit plus a payload.
// Ports:
//  clk      in   clock
//  rst_n    in   asynchronous reset, active low
//  clr      in   invalidate the slot (payload zeroed when ZERO_INVALID)
//  ld       in   load ld_data and mark the slot valid
//  ld_data  in   payload to load
//  valid    out  slot holds a bundle
//  data     out  stored payload
// clr wins over ld, which is what lets a flush discard a same-cycle load.
// ----------------------------------------------------------------------------
module pipe_entry #(
    parameter int DATA_W       = 256,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              ld,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            if (ZERO_INVALID) begin
                data <= '0;
            end
        end else if (ld) begin
            valid <= 1'b1;
            data  <= ld_data;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// ----------------------------------------------------------------------------
// pipe_stage_buf
// Inter-stage pipeline register with valid/allowin handshake and flush.
// Parameters:
//  DATA_W        payload width (packed stage bundle)
//  SKID          0: single entry, in_ready combinational from out_ready
//                1: 2-entry skid buffer, in_ready comes straight from a flop
//  ZERO_INVALID  1: out_data is 0 whenever out_valid is 0
// Ports:
//  clk, rst_n              clock, asynchronous active-low reset
//  flush                   drop everything held (WB exception / ertn)
//  in_valid/in_ready/in_data     upstream handshake and bundle
//  out_valid/out_ready/out_data  downstream handshake and bundle
//  occupancy               number of bundles held (0..1 or 0..2)
// ----------------------------------------------------------------------------
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W       = 256,
    parameter bit SKID         = 1'b0,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_v;
    logic [DATA_W-1:0] main_d;
    logic              main_ld;
    logic              main_clr;
    logic [DATA_W-1:0] main_din;
    logic              accept;
    logic              emit;

    assign accept    = in_valid && in_ready;
    assign emit      = main_v && out_ready;
    assign out_valid = main_v;

    // The register is already zeroed on clear, but masking here also covers
    // ZERO_INVALID with an entry that was never written through clr.
    assign out_data = (ZERO_INVALID && !main_v) ? '0 : main_d;

    pipe_entry #(
        .DATA_W       (DATA_W),
        .ZERO_INVALID (ZERO_INVALID)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (main_clr),
        .ld      (main_ld),
        .ld_data (main_din),
        .valid   (main_v),
        .data    (main_d)
    );

    generate
        if (SKID == 1'b0) begin : g_single

            // A draining slot can be refilled in the same cycle, so readiness
            // depends on out_ready of the downstream stage.
            assign in_ready  = !main_v || out_ready;
            assign main_ld   = accept;
            assign main_clr  = flush || (emit && !accept);
            assign main_din  = in_data;
            assign occupancy = {1'b0, main_v};

        end else begin : g_skid

            buf_state_e        state_q;
            buf_state_e        state_d;
            logic              ready_q;
            logic              skid_v;
            logic [DATA_W-1:0] skid_d;
            logic              skid_ld;
            logic              skid_clr;

            pipe_entry #(
                .DATA_W       (DATA_W),
                .ZERO_INVALID (ZERO_INVALID)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (skid_clr),
                .ld      (skid_ld),
                .ld_data (in_data),
                .valid   (skid_v),
                .data    (skid_d)
            );

            // Next state and entry controls. The main entry is always the
            // head of the FIFO; the skid entry only holds the second bundle.
            always_comb begin
                state_d  = state_q;
                main_ld  = 1'b0;
                main_clr = 1'b0;
                main_din = in_data;
                skid_ld  = 1'b0;
                skid_clr = 1'b0;
                if (flush) begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (accept) begin
                                main_ld = 1'b1;
                                state_d = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (accept && emit) begin
                                main_ld = 1'b1;
                            end else if (accept) begin
                                skid_ld = 1'b1;
                                state_d = ST_FULL;
                            end else if (emit) begin
                                main_clr = 1'b1;
                                state_d  = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (emit) begin
                                main_ld  = 1'b1;
                                main_din = skid_d;
                                skid_clr = 1'b1;
                                state_d  = ST_ONE;
                            end
                        end
                        default: begin
                            state_d  = ST_EMPTY;
                            main_clr = 1'b1;
                            skid_clr = 1'b1;
                        end
                    endcase
                end
            end

            // ready_q is precomputed from the next state so in_ready has no
            // combinational path from out_ready.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= ST_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    state_q <= state_d;
                    ready_q <= (state_d != ST_FULL);
                end
            end

            assign in_ready  = ready_q;
            assign occupancy = occ_count(main_v, skid_v);

        end
    endgenerate

endmodule
